sr_frame_scheduler: RTL and testbench



---
 rtl/sr_sched_pkg.sv | 21 ++
 rtl/sr_serializer.sv | 117 +++++++++++
 rtl/sr_frame_scheduler.sv | 116 +++++++++++
 tb/tb_sr_frame_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_sched_pkg.sv
// Shared types and defaults for the 74HC595 frame scheduler and its serializer.
package sr_sched_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StShiftLo,
        StShiftHi,
        StLatch
    } sched_state_e;

    localparam int unsigned StageWidth           = 8;
    localparam int unsigned DefaultClkDiv        = 4;
    localparam logic [23:0] DefaultRefreshCycles = 24'd13500000;

    function automatic int unsigned rr_index(input int unsigned base, input int unsigned offset,
                                             input int unsigned n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/sr_serializer.sv
// Shifts one snapshot of the shadow frame onto SHCP/DS, MSB of the top stage first,
// then pulses STCP once to latch the whole chain.
module sr_serializer
    import sr_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned CLK_DIV = DefaultClkDiv
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_start,
    input  logic [StageWidth*NUM_REQ-1:0] i_frame,
    output logic                          o_load,
    output logic                          o_busy,
    output logic                          o_STCP,
    output logic                          o_SHCP,
    output logic                          o_DS
);

    localparam int unsigned FrameBits = StageWidth * NUM_REQ;
    localparam int unsigned BitCntW   = $clog2(FrameBits) + 1;
    localparam int unsigned HalfCntW  = $clog2(CLK_DIV) + 1;
    localparam logic [BitCntW-1:0]  LastBit  = BitCntW'(FrameBits - 1);
    localparam logic [HalfCntW-1:0] LastHalf = HalfCntW'(CLK_DIV - 1);

    sched_state_e          r_state, w_state_d;
    logic [FrameBits-1:0]  r_frame, w_frame_d;
    logic [BitCntW-1:0]    r_bit_cnt, w_bit_cnt_d;
    logic [HalfCntW-1:0]   r_half_cnt, w_half_cnt_d;
    logic                  r_ds, w_ds_d;
    logic                  w_half_done;
    logic                  w_last_bit;

    assign w_half_done = (r_half_cnt == LastHalf);
    assign w_last_bit  = (r_bit_cnt == LastBit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:    if (i_start) w_state_d = StLoad;
            StLoad:    w_state_d = StShiftLo;
            StShiftLo: if (w_half_done) w_state_d = StShiftHi;
            StShiftHi: if (w_half_done) w_state_d = w_last_bit ? StLatch : StShiftLo;
            StLatch:   if (w_half_done) w_state_d = StIdle;
            default:   w_state_d = StIdle;
        endcase
    end

    // DS is only reloaded on entry to SHIFT_LO so it stays stable across the SHCP rise.
    always_comb begin
        w_frame_d    = r_frame;
        w_bit_cnt_d  = r_bit_cnt;
        w_half_cnt_d = r_half_cnt;
        w_ds_d       = r_ds;
        unique case (r_state)
            StIdle: begin
                w_bit_cnt_d  = '0;
                w_half_cnt_d = '0;
            end
            StLoad: begin
                w_frame_d    = i_frame;
                w_bit_cnt_d  = '0;
                w_half_cnt_d = '0;
                w_ds_d       = i_frame[FrameBits-1];
            end
            StShiftLo, StLatch: begin
                w_half_cnt_d = w_half_done ? '0 : r_half_cnt + 1'b1;
            end
            StShiftHi: begin
                if (w_half_done) begin
                    w_half_cnt_d = '0;
                    if (!w_last_bit) begin
                        w_bit_cnt_d = r_bit_cnt + 1'b1;
                        w_frame_d   = r_frame << 1;
                        w_ds_d      = r_frame[FrameBits-2];
                    end
                end else begin
                    w_half_cnt_d = r_half_cnt + 1'b1;
                end
            end
            default: begin
                w_half_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame    <= '0;
            r_bit_cnt  <= '0;
            r_half_cnt <= '0;
            r_ds       <= 1'b0;
        end else begin
            r_frame    <= w_frame_d;
            r_bit_cnt  <= w_bit_cnt_d;
            r_half_cnt <= w_half_cnt_d;
            r_ds       <= w_ds_d;
        end
    end

    always_comb begin
        o_load = (r_state == StLoad);
        o_busy = (r_state != StIdle);
        o_SHCP = (r_state == StShiftHi);
        o_STCP = (r_state == StLatch);
        o_DS   = r_ds;
    end

endmodule

// File: rtl/sr_frame_scheduler.sv
// Round-robin byte writers into shadow registers, re-pushed to a 74HC595 chain on change.
// Optional periodic re-push when SR_AUTO_REFRESH_EN is defined.
module sr_frame_scheduler
    import sr_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned CLK_DIV        = DefaultClkDiv,
    parameter logic [23:0] REFRESH_CYCLES = DefaultRefreshCycles
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [StageWidth*NUM_REQ-1:0] i_data,
    output logic [NUM_REQ-1:0]            o_ack,
    output logic                          o_busy,
    output logic                          o_STCP,
    output logic                          o_SHCP,
    output logic                          o_DS
);

    localparam int unsigned PtrW = $clog2(NUM_REQ);

    logic [StageWidth*NUM_REQ-1:0] r_shadow;
    logic [NUM_REQ-1:0]            r_ack;
    logic [PtrW-1:0]               r_rr_ptr, w_rr_ptr_d;
    logic                          r_dirty, w_dirty_d;
    logic [NUM_REQ-1:0]            w_req_m;
    logic [NUM_REQ-1:0]            w_grant;
    logic                          w_grant_any;
    logic                          w_load;
    logic                          w_busy;
    logic                          w_refresh;

    // A requester being acked this cycle is still holding req; mask it to avoid a double accept.
    assign w_req_m = i_req & ~r_ack;

    always_comb begin
        logic [PtrW-1:0] cand;
        cand        = '0;
        w_grant     = '0;
        w_grant_any = 1'b0;
        w_rr_ptr_d  = r_rr_ptr;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = PtrW'(rr_index(32'(r_rr_ptr), i, NUM_REQ));
            if (!w_grant_any && w_req_m[cand]) begin
                w_grant_any       = 1'b1;
                w_grant[cand]     = 1'b1;
                w_rr_ptr_d        = PtrW'(rr_index(32'(cand), 1, NUM_REQ));
            end
        end
    end

`ifdef SR_AUTO_REFRESH_EN
    logic [23:0] r_idle_cnt;
    logic        w_idle_clean;

    assign w_idle_clean = !w_busy && !r_dirty;
    assign w_refresh    = w_idle_clean && (r_idle_cnt == REFRESH_CYCLES - 24'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle_cnt <= '0;
        end else if (w_grant_any || w_refresh) begin
            r_idle_cnt <= '0;
        end else if (w_idle_clean) begin
            r_idle_cnt <= r_idle_cnt + 24'd1;
        end
    end
`else
    assign w_refresh = 1'b0;
    if (REFRESH_CYCLES == 24'd0) begin : g_refresh_unused
    end
`endif

    // A grant in the LOAD cycle must survive the clear so the write reaches the next frame.
    always_comb begin
        w_dirty_d = r_dirty;
        if (w_load) w_dirty_d = 1'b0;
        if (w_refresh || w_grant_any) w_dirty_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '0;
            r_ack    <= '0;
            r_rr_ptr <= '0;
            r_dirty  <= 1'b1;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (w_grant[k]) r_shadow[k*StageWidth +: StageWidth] <= i_data[k*StageWidth +: StageWidth];
            end
            r_ack    <= w_grant;
            r_rr_ptr <= w_rr_ptr_d;
            r_dirty  <= w_dirty_d;
        end
    end

    sr_serializer #(
        .NUM_REQ(NUM_REQ),
        .CLK_DIV(CLK_DIV)
    ) u_serializer (
        .clk    (clk),
        .rst    (rst),
        .i_start(r_dirty),
        .i_frame(r_shadow),
        .o_load (w_load),
        .o_busy (w_busy),
        .o_STCP (o_STCP),
        .o_SHCP (o_SHCP),
        .o_DS   (o_DS)
    );

    assign o_ack  = r_ack;
    assign o_busy = w_busy;

endmodule

// File: tb/tb_sr_frame_scheduler.sv
// Self-checking bench for sr_frame_scheduler with two requesters and CLK_DIV=2.
module tb_sr_frame_scheduler;

    localparam int unsigned NR = 2;
    localparam int unsigned CD = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   req = '0;
    logic [8*NR-1:0] data = '0;
    logic [NR-1:0]   ack;
    logic            busy, stcp, shcp, ds;

    int n_pass  = 0;
    int n_total = 0;

    // Captured frames: {bit count, frame bits}, pushed on each STCP rise.
    logic [31:0] cap_q[$];
    logic [31:0] exp_q[$];
    logic [15:0] m_frame = '0;

    logic [15:0] acc = '0;
    int          acc_n = 0;
    logic        p_shcp = 1'b0, p_stcp = 1'b0, p_busy = 1'b0;
    int          busy_run = 0, last_busy_len = 0;
    int          stcp_run = 0, last_stcp_len = 0;
    int          stcp_rises = 0, busy_rises = 0;

    always #5 clk = ~clk;

    sr_frame_scheduler #(
        .NUM_REQ       (NR),
        .CLK_DIV       (CD),
        .REFRESH_CYCLES(24'd100)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .i_req (req),
        .i_data(data),
        .o_ack (ack),
        .o_busy(busy),
        .o_STCP(stcp),
        .o_SHCP(shcp),
        .o_DS  (ds)
    );

    always @(negedge clk) begin
        if (rst) begin
            acc      <= '0;
            acc_n    <= 0;
            p_shcp   <= 1'b0;
            p_stcp   <= 1'b0;
            p_busy   <= 1'b0;
            busy_run <= 0;
            stcp_run <= 0;
        end else begin
            p_shcp <= shcp;
            p_stcp <= stcp;
            p_busy <= busy;
            if (shcp && !p_shcp) begin
                acc   <= {acc[14:0], ds};
                acc_n <= acc_n + 1;
            end
            if (stcp && !p_stcp) begin
                cap_q.push_back({acc_n[15:0], acc});
                stcp_rises <= stcp_rises + 1;
                acc        <= '0;
                acc_n      <= 0;
            end
            if (busy) busy_run <= busy_run + 1;
            else if (p_busy) begin
                last_busy_len <= busy_run;
                busy_run      <= 0;
            end
            if (busy && !p_busy) busy_rises <= busy_rises + 1;
            if (stcp) stcp_run <= stcp_run + 1;
            else if (p_stcp) begin
                last_stcp_len <= stcp_run;
                stcp_run      <= 0;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && busy; i++) step();
    endtask

    task automatic wait_bits(input int n);
        for (int i = 0; i < 400 && acc_n < n; i++) step();
    endtask

    task automatic wait_frame(output logic [31:0] got, output bit ok);
        ok  = 1'b0;
        got = '0;
        for (int i = 0; i < 400; i++) begin
            if (cap_q.size() > 0) begin
                got = cap_q.pop_front();
                ok  = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic do_write(input int k, input logic [7:0] b, output bit ok);
        ok = 1'b0;
        data[8*k +: 8] = b;
        req[k] = 1'b1;
        for (int i = 0; i < NR + 4; i++) begin
            step();
            if (ack[k]) begin
                ok = 1'b1;
                break;
            end
        end
        req[k] = 1'b0;
        if (ok) m_frame[8*k +: 8] = b;
    endtask

    task automatic test_reset();
        logic [31:0] got, exp;
        bit ok;
        rst = 1'b1;
        step();
        step();
        n_total++;
        if (ack !== 2'b00) $display("FAIL reset_ack got=%b exp=00", ack); else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
        n_total++;
        if ({stcp, shcp, ds} !== 3'b000) $display("FAIL reset_pins got=%b exp=000", {stcp, shcp, ds});
        else n_pass++;
        m_frame = '0;
        exp_q.push_back({16'd16, m_frame});
        @(negedge clk);
        rst = 1'b0;
        wait_frame(got, ok);
        exp = exp_q.pop_front();
        n_total++;
        if (!ok || got !== exp) $display("FAIL reset_frame got=%h exp=%h", got, exp); else n_pass++;
        wait_idle();
        n_total++;
        if (last_busy_len != 67) $display("FAIL busy_len got=%0d exp=67", last_busy_len);
        else n_pass++;
        n_total++;
        if (last_stcp_len != CD) $display("FAIL stcp_width got=%0d exp=%0d", last_stcp_len, CD);
        else n_pass++;
    endtask

    task automatic test_contention();
        logic [31:0] got, exp;
        bit ok;
        wait_idle();
        data = {8'hAA, 8'h55};
        req  = 2'b11;
        step();
        n_total++;
        if (ack !== 2'b01) $display("FAIL cont_ack0 got=%b exp=01", ack); else n_pass++;
        req[0] = 1'b0;
        step();
        n_total++;
        if (ack !== 2'b10) $display("FAIL cont_ack1 got=%b exp=10", ack); else n_pass++;
        req[1] = 1'b0;
        step();
        n_total++;
        if (ack !== 2'b00) $display("FAIL cont_ack_end got=%b exp=00", ack); else n_pass++;
        m_frame = 16'hAA55;
        exp_q.push_back({16'd16, m_frame});
        wait_frame(got, ok);
        exp = exp_q.pop_front();
        n_total++;
        if (!ok || got !== exp) $display("FAIL cont_frame got=%h exp=%h", got, exp); else n_pass++;
        wait_idle();
        repeat (20) step();
        n_total++;
        if (cap_q.size() != 0 || busy !== 1'b0)
            $display("FAIL cont_extra got=%0d frames exp=0", cap_q.size());
        else n_pass++;
    endtask

    task automatic test_single_write();
        logic [31:0] got, exp;
        bit ok;
        wait_idle();
        data[7:0] = 8'hA5;
        req       = 2'b01;
        step();
        n_total++;
        if (ack !== 2'b01) $display("FAIL single_ack got=%b exp=01", ack); else n_pass++;
        req = 2'b00;
        m_frame[7:0] = 8'hA5;
        exp_q.push_back({16'd16, m_frame});
        step();
        n_total++;
        if (ack !== 2'b00) $display("FAIL single_ack_pulse got=%b exp=00", ack); else n_pass++;
        wait_frame(got, ok);
        exp = exp_q.pop_front();
        n_total++;
        if (!ok || got !== exp) $display("FAIL single_frame got=%h exp=%h", got, exp); else n_pass++;
    endtask

    task automatic test_write_during_frame();
        logic [31:0] got, exp;
        bit ok;
        wait_idle();
        do_write(0, 8'h3C, ok);
        n_total++;
        if (!ok) $display("FAIL wdf_ack0 got=timeout exp=ack"); else n_pass++;
        exp_q.push_back({16'd16, m_frame});
        wait_bits(5);
        do_write(1, 8'hFF, ok);
        n_total++;
        if (!ok) $display("FAIL wdf_ack1 got=timeout exp=ack"); else n_pass++;
        do_write(0, 8'h3C, ok);
        n_total++;
        if (!ok) $display("FAIL wdf_ack2 got=timeout exp=ack"); else n_pass++;
        exp_q.push_back({16'd16, m_frame});
        wait_frame(got, ok);
        exp = exp_q.pop_front();
        n_total++;
        if (!ok || got !== exp) $display("FAIL wdf_frame1 got=%h exp=%h", got, exp); else n_pass++;
        wait_frame(got, ok);
        exp = exp_q.pop_front();
        n_total++;
        if (!ok || got !== exp) $display("FAIL wdf_frame2 got=%h exp=%h", got, exp); else n_pass++;
        wait_idle();
        repeat (40) step();
        n_total++;
        if (cap_q.size() != 0 || busy !== 1'b0)
            $display("FAIL wdf_extra got=%0d frames exp=0", cap_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] got, exp;
        bit ok;
        int rises0;
        wait_idle();
        do_write(0, 8'h11, ok);
        wait_bits(4);
        step();
        step();
        n_total++;
        if (busy !== 1'b1) $display("FAIL rmf_busy_before got=%b exp=1", busy); else n_pass++;
        rises0 = stcp_rises;
        rst = 1'b1;
        #1;
        n_total++;
        if ({stcp, shcp, ds} !== 3'b000) $display("FAIL rmf_pins got=%b exp=000", {stcp, shcp, ds});
        else n_pass++;
        n_total++;
        if (busy !== 1'b0 || ack !== 2'b00) $display("FAIL rmf_busy_ack got=%b%b exp=000", busy, ack);
        else n_pass++;
        repeat (3) step();
        n_total++;
        if (stcp_rises != rises0) $display("FAIL rmf_no_stcp got=%0d exp=%0d", stcp_rises, rises0);
        else n_pass++;
        m_frame = '0;
        exp_q.push_back({16'd16, m_frame});
        rst = 1'b0;
        wait_frame(got, ok);
        exp = exp_q.pop_front();
        n_total++;
        if (!ok || got !== exp) $display("FAIL rmf_frame got=%h exp=%h", got, exp); else n_pass++;
        step();
        n_total++;
        if (stcp_rises != rises0 + 1) $display("FAIL rmf_stcp_cnt got=%0d exp=%0d", stcp_rises, rises0 + 1);
        else n_pass++;
    endtask

    task automatic test_refresh();
        int b0;
        wait_idle();
        cap_q.delete();
        b0 = busy_rises;
        repeat (300) step();
`ifdef SR_AUTO_REFRESH_EN
        n_total++;
        if (busy_rises <= b0) $display("FAIL refresh_frames got=%0d exp=>%0d", busy_rises, b0);
        else n_pass++;
        n_total++;
        if (cap_q.size() == 0 || cap_q[0] !== {16'd16, m_frame})
            $display("FAIL refresh_content got=%0d frames exp=%h", cap_q.size(), m_frame);
        else n_pass++;
`else
        n_total++;
        if (busy_rises != b0) $display("FAIL no_refresh got=%0d exp=%0d", busy_rises - b0, 0);
        else n_pass++;
        n_total++;
        if (cap_q.size() != 0) $display("FAIL no_refresh_frames got=%0d exp=0", cap_q.size());
        else n_pass++;
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_contention();
        test_single_write();
        test_write_during_frame();
        test_reset_mid_frame();
        test_refresh();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
